dram_ctrl: RTL and testbench

Synthesizable single-port controller that drives an asynchronous 1M×16 DRAM chip (RAS/UCAS/LCAS/WE, 10-bit multiplexed address, 16-bit bidirectional data) from a simple request/acknowledge interface clocked by fclk. It sequences read, byte-masked write and CAS-before-RAS refresh cycles with fixed, registered strobe timing. It sits between the system arbiter and the board DRAM pins.

---
 rtl/dram_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dram_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// dram_ctrl: request/ack sequencer for an asynchronous 1Mx16 DRAM with registered strobes.
// Define DRAM_REFRESH_EN to compile in the CAS-before-RAS refresh timer and states.
module dram_ctrl
`ifdef DRAM_REFRESH_EN
#(
    parameter int REFDIV = 436
)
`endif
(
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [19:0] addr,
    input  logic [1:0]  bsel,
    input  logic [15:0] wrdata,
    output logic        ack,
    output logic [15:0] rddata,
    output logic        rrdy,
    output logic [9:0]  ra,
    inout  logic [15:0] rd,
    output logic        rras_n,
    output logic        rucas_n,
    output logic        rlcas_n,
    output logic        rwe_n
);
    typedef enum logic [3:0] {IDLE, RCD, CAS, HOLD, PRE, RCAS, RRAS, RHOLD, RPRE} state_t;

    state_t      state, state_d;
    logic        rnw_q, rnw_d;
    logic [9:0]  col_q, col_d, ra_d;
    logic [1:0]  bsel_q, bsel_d;
    logic [15:0] wdata_q, wdata_d, rddata_d;
    logic        oe, oe_d, ras_d, ucas_d, lcas_d, we_d, ack_d, rrdy_d;
    logic        ref_due;

`ifdef DRAM_REFRESH_EN
    localparam int CW = $clog2(REFDIV);
    logic [CW-1:0] rcnt;
    logic [1:0]    pend;
    logic          wrap, ref_take;

    assign wrap    = rcnt == CW'(REFDIV - 1);
    assign ref_due = pend != 2'd0;

    // Pending refreshes saturate at 3; a wrap and a started refresh in the same cycle cancel.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            pend <= '0;
        end else begin
            rcnt <= wrap ? '0 : rcnt + 1'b1;
            pend <= pend + {1'b0, wrap && pend != 2'd3} - {1'b0, ref_take};
        end
    end
`else
    assign ref_due = 1'b0;
`endif

    assign rd = oe ? wdata_q : 16'hzzzz;

    always_comb begin
        state_d  = state;
        rnw_d    = rnw_q;
        col_d    = col_q;
        bsel_d   = bsel_q;
        wdata_d  = wdata_q;
        rddata_d = rddata;
        ra_d     = ra;
        ras_d    = rras_n;
        ucas_d   = rucas_n;
        lcas_d   = rlcas_n;
        we_d     = rwe_n;
        oe_d     = oe;
        ack_d    = 1'b0;
        rrdy_d   = 1'b0;
`ifdef DRAM_REFRESH_EN
        ref_take = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ref_due) begin
                    state_d = RCAS;
`ifdef DRAM_REFRESH_EN
                    ref_take = 1'b1;
`endif
                end else if (req) begin
                    rnw_d   = rnw;
                    col_d   = addr[19:10];
                    bsel_d  = rnw ? 2'b11 : bsel;
                    wdata_d = wrdata;
                    ra_d    = addr[9:0];
                    ras_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RCD;
                end
            end
            RCD: begin
                ra_d    = col_q;
                we_d    = rnw_q;
                oe_d    = ~rnw_q;
                state_d = CAS;
            end
            CAS: begin
                ucas_d  = ~bsel_q[1];
                lcas_d  = ~bsel_q[0];
                state_d = HOLD;
            end
            HOLD: begin
                rddata_d = rnw_q ? rd : rddata;
                rrdy_d   = rnw_q;
                state_d  = PRE;
            end
            PRE: begin
                ras_d   = 1'b1;
                ucas_d  = 1'b1;
                lcas_d  = 1'b1;
                we_d    = 1'b1;
                oe_d    = 1'b0;
                state_d = IDLE;
            end
`ifdef DRAM_REFRESH_EN
            RCAS: begin
                ra_d    = '0;
                ucas_d  = 1'b0;
                lcas_d  = 1'b0;
                state_d = RRAS;
            end
            RRAS: begin
                ras_d   = 1'b0;
                state_d = RHOLD;
            end
            RHOLD: state_d = RPRE;
            RPRE: begin
                ras_d   = 1'b1;
                ucas_d  = 1'b1;
                lcas_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rnw_q   <= 1'b1;
            col_q   <= '0;
            bsel_q  <= '0;
            wdata_q <= '0;
            rddata  <= '0;
            ra      <= '0;
            rras_n  <= 1'b1;
            rucas_n <= 1'b1;
            rlcas_n <= 1'b1;
            rwe_n   <= 1'b1;
            oe      <= 1'b0;
            ack     <= 1'b0;
            rrdy    <= 1'b0;
        end else begin
            state   <= state_d;
            rnw_q   <= rnw_d;
            col_q   <= col_d;
            bsel_q  <= bsel_d;
            wdata_q <= wdata_d;
            rddata  <= rddata_d;
            ra      <= ra_d;
            rras_n  <= ras_d;
            rucas_n <= ucas_d;
            rlcas_n <= lcas_d;
            rwe_n   <= we_d;
            oe      <= oe_d;
            ack     <= ack_d;
            rrdy    <= rrdy_d;
        end
    end
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed bench for dram_ctrl with a behavioural DRAM model on the pins.
module tb_dram_ctrl;
    logic        fclk = 1'b0, rst_n = 1'b1, req = 1'b0, rnw = 1'b1;
    logic [19:0] addr = '0;
    logic [1:0]  bsel = '0;
    logic [15:0] wrdata = '0;
    logic        ack, rrdy, rras_n, rucas_n, rlcas_n, rwe_n;
    logic [15:0] rddata;
    logic [9:0]  ra;
    wire  [15:0] rd;

    int n_cmp = 0, n_bad = 0;

`ifdef DRAM_REFRESH_EN
    dram_ctrl #(.REFDIV(8)) dut (.*);
`else
    dram_ctrl dut (.*);
`endif

    always #5 fclk = ~fclk;

    for (genvar g = 0; g < 16; g++) begin : g_pd
        pulldown (rd[g]);
    end

    logic [15:0] mem [int];
    logic [15:0] rd_val = '0;
    logic [9:0]  row = '0;
    logic        pras = 1'b1, pucas = 1'b1, plcas = 1'b1;
    int          cyc = 0, ras_falls = 0, ucas_falls = 0, lcas_falls = 0, refs = 0, cbr_err = 0, cbr_cyc = -10;
    logic [19:0] wlog [$];

    assign rd = (!rras_n && (!rucas_n || !rlcas_n) && rwe_n) ? rd_val : 16'hzzzz;

    always @(negedge fclk) begin
        logic [19:0] a;
        logic [15:0] w;
        cyc++;
        if (!rras_n && pras) begin
            if (pucas && plcas) begin
                row = ra;
                ras_falls++;
            end else begin
                refs++;
                if (cyc - cbr_cyc != 1 || !rwe_n) cbr_err++;
            end
        end
        if ((!rucas_n && pucas) || (!rlcas_n && plcas)) begin
            if (rras_n) cbr_cyc = cyc;
            else begin
                a = {ra, row};
                w = mem.exists(a) ? mem[a] : 16'h0;
                if (!rucas_n && pucas) begin
                    ucas_falls++;
                    if (!rwe_n) w[15:8] = rd[15:8];
                end
                if (!rlcas_n && plcas) begin
                    lcas_falls++;
                    if (!rwe_n) w[7:0] = rd[7:0];
                end
                if (!rwe_n) begin
                    mem[a] = w;
                    wlog.push_back(a);
                end
            end
        end
        rd_val = mem.exists({ra, row}) ? mem[{ra, row}] : 16'h0;
        pras  = rras_n;
        pucas = rucas_n;
        plcas = rlcas_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic r, input logic [19:0] a, input logic [1:0] b, input logic [15:0] d,
                        output logic [15:0] q, output int la, output int lr);
        q = '0; la = -1; lr = -1;
        rnw = r; addr = a; bsel = b; wrdata = d; req = 1'b1;
        for (int i = 1; i <= 40 && la < 0; i++) begin
            @(posedge fclk); #1;
            if (ack) la = i;
        end
        req = 1'b0;
        if (la < 0) check("ack_timeout", ack, 1);
        else if (r) begin
            for (int i = 1; i <= 40 && lr < 0; i++) begin
                @(posedge fclk); #1;
                if (rrdy) lr = i;
            end
            if (lr < 0) check("rrdy_timeout", rrdy, 1);
            else q = rddata;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fclk); #1;
        end
    endtask

    initial begin
        logic [15:0] q;
        int la, lr, u0, l0, r0, got, seen;
        int stamp [3];
        logic [19:0] ba [3] = '{20'h0A001, 20'h0A002, 20'hFFC03};
        logic [15:0] bd [3] = '{16'h1001, 16'h2002, 16'h3003};

        #2 rst_n = 1'b0;
        idle(3);
        check("rst_strobes", {rras_n, rucas_n, rlcas_n, rwe_n}, 4'hF);
        check("rst_rd", rd, 16'h0);
        check("rst_ack_rrdy", {ack, rrdy}, 2'b00);
        check("rst_ra", ra, 10'h0);
        check("rst_rddata", rddata, 16'h0);
        rst_n = 1'b1;
        idle(2);

        xfer(1'b0, 20'h12345, 2'b11, 16'hBEEF, q, la, lr);
        check("wr_ack_lat", la, 1);
        check("ras_with_ack", rras_n, 0);
        xfer(1'b1, 20'h12345, 2'b00, 16'h0, q, la, lr);
        check("rd_rrdy_lat", lr, 3);
        check("rd_beef", q, 16'hBEEF);

        u0 = ucas_falls; l0 = lcas_falls;
        xfer(1'b0, 20'h12345, 2'b10, 16'h55AA, q, la, lr);
        idle(5);
        check("bw_ucas", ucas_falls - u0, 1);
        check("bw_lcas", lcas_falls - l0, 0);
        xfer(1'b1, 20'h12345, 2'b00, 16'h0, q, la, lr);
        check("bw_data", q, 16'h55EF);

        xfer(1'b0, 20'h00777, 2'b11, 16'hA5A5, q, la, lr);
        idle(5);
        r0 = ras_falls; u0 = ucas_falls; l0 = lcas_falls;
        xfer(1'b0, 20'h00777, 2'b00, 16'h1234, q, la, lr);
        idle(5);
        check("b00_ras", ras_falls - r0, 1);
        check("b00_cas", (ucas_falls - u0) + (lcas_falls - l0), 0);
        xfer(1'b1, 20'h00777, 2'b00, 16'h0, q, la, lr);
        check("b00_data", q, 16'hA5A5);

        idle(4);
        wlog.delete();
        req = 1'b1; rnw = 1'b0; bsel = 2'b11;
        for (int k = 0; k < 3; k++) begin
            addr = ba[k]; wrdata = bd[k]; got = 0;
            for (int i = 0; i < 40 && got == 0; i++) begin
                @(posedge fclk); #1;
                if (ack) got = 1;
            end
            check("b2b_ack", got, 1);
            stamp[k] = cyc;
        end
        req = 1'b0;
        for (int k = 1; k < 3; k++)
`ifdef DRAM_REFRESH_EN
            check("b2b_spacing_min", (stamp[k] - stamp[k-1]) >= 5, 1);
`else
            check("b2b_spacing", stamp[k] - stamp[k-1], 5);
`endif
        idle(6);
        check("b2b_wcount", wlog.size(), 3);
        for (int k = 0; k < 3 && k < wlog.size(); k++) check("b2b_order", wlog[k], ba[k]);
        for (int k = 0; k < 3; k++) begin
            xfer(1'b1, ba[k], 2'b00, 16'h0, q, la, lr);
            check("b2b_data", q, bd[k]);
        end

`ifdef DRAM_REFRESH_EN
        r0 = refs;
        for (int k = 0; k < 10; k++) begin
            xfer(1'b1, ba[k % 3], 2'b00, 16'h0, q, la, lr);
            check("ref_rd_data", q, bd[k % 3]);
        end
        check("ref_count_min", (refs - r0) >= 4, 1);
        check("ref_cbr", cbr_err, 0);
`else
        check("no_refresh", refs, 0);
`endif

        xfer(1'b0, 20'h00ABC, 2'b11, 16'h1111, q, la, lr);
        idle(2);
        check("hold_cas", {rucas_n, rlcas_n, rwe_n}, 3'b000);
        check("hold_rd", rd, 16'h1111);
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {rras_n, rucas_n, rlcas_n, rwe_n}, 4'hF);
        check("mid_rst_rd", rd, 16'h0);
        check("mid_rst_ra", ra, 10'h0);
        idle(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge fclk); #1;
            if (ack || rrdy || !rras_n || !rucas_n || !rlcas_n || !rwe_n) seen = 1;
        end
        check("post_rst_quiet", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
